// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        NONE,
        I_READ,
        D_READ,
        D_ERR
    } owner_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_be_gen.sv
// Big-endian byte-enable generator for data accesses; bit 3 is the lane at byte offset 0.
module mem_arbiter_be_gen
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misaligned
);

    always_comb begin
        be         = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: be = 4'b1000 >> addr;
            SZ_WORD: begin
                be         = addr[1] ? 4'b0011 : 4'b1100;
                misaligned = addr[0];
            end
            SZ_LONG: begin
                be         = BE_ALL;
                misaligned = |addr;
            end
            // The reserved size code can never be serviced, so it reports as misaligned.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and data access.
// Define MEM_ARBITER_ROUND_ROBIN_EN to replace fixed data priority + starvation guard with round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_stall
);

    logic [3:0]            d_be;
    logic                  d_mis;
    logic                  i_win;
    logic                  d_win;
    logic                  i_prio;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    owner_e                owner_q;
    owner_e                owner_d;

    mem_arbiter_be_gen u_be_gen (
        .size       (d_size),
        .addr       (d_addr[1:0]),
        .be         (d_be),
        .misaligned (d_mis)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_i;

    // Starts as if the fetch side won last, so data goes first out of reset.
    always_ff @(posedge clk) begin
        if (reset)      last_i <= 1'b1;
        else if (i_win) last_i <= 1'b1;
        else if (d_win) last_i <= 1'b0;
    end

    assign i_prio = ~last_i;
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (i_req & ~i_win)
            starve_cnt <= (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                               : starve_cnt + CNT_W'(1);
        else
            starve_cnt <= '0;
    end

    assign i_prio = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif

    // Everything is forced quiet while reset is held, including stall and responses.
    always_comb begin
        i_win     = ~reset & i_req & (~d_req | i_prio);
        d_win     = ~reset & d_req & ~i_win;
        mem_en    = i_win | (d_win & ~d_mis);
        mem_we    = d_win & ~d_mis & d_we;
        cmd_addr  = i_win ? i_addr : d_addr;
        mem_addr  = mem_en ? (cmd_addr & ~ADDR_WIDTH'(3)) : '0;
        mem_be    = i_win ? BE_ALL : ((d_win & ~d_mis) ? d_be : 4'b0000);
        mem_wdata = mem_we ? d_wdata : '0;
        i_gnt     = i_win;
        d_gnt     = d_win;
        cpu_stall = ~reset & ((i_req & ~i_win) | (d_req & ~d_win));

        owner_d = NONE;
        if (i_win)      owner_d = I_READ;
        else if (d_win) owner_d = d_mis ? D_ERR : (d_we ? NONE : D_READ);
    end

    always_ff @(posedge clk) begin
        if (reset) owner_q <= NONE;
        else       owner_q <= owner_d;
    end

    always_comb begin
        i_rvalid = ~reset & (owner_q == I_READ);
        d_rvalid = ~reset & ((owner_q == D_READ) | (owner_q == D_ERR));
        d_err    = ~reset & (owner_q == D_ERR);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = (~reset & (owner_q == D_READ)) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic
// scored against a byte-lane reference model and a small RAM image.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [1:0]    d_size = 2'b10;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_stall;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          denied;
    bit          last_was_d;
    int          pend;
    logic [31:0] pend_data;
    logic [31:0] ref_mem [16];
    bit          m_i_gnt, m_d_gnt;

    logic [31:0] ram [16];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    function automatic logic [31:0] init_word(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    // Single-port synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) ram[k] <= init_word(k);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[5:2]];
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs for the current inputs, advance the model, move to next cycle.
    task automatic run_cycle();
        logic        e_i, e_d, e_en, e_we, e_stall, e_irv, e_drv, e_err, mis;
        logic [3:0]  e_be, lanes;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        int          nb, off;
        e_i = 0; e_d = 0; e_en = 0; e_we = 0; e_stall = 0; e_irv = 0; e_drv = 0; e_err = 0;
        mis = 0; e_be = 0; lanes = 0; e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
        #1;
        if (!reset) begin
            e_irv = (pend == 1);
            e_drv = (pend == 2) || (pend == 3);
            e_err = (pend == 3);
            e_ird = (pend == 1) ? pend_data : 32'h0;
            e_drd = (pend == 2) ? pend_data : 32'h0;

            nb  = (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : (d_size == 2'd2) ? 4 : 0;
            off = int'(d_addr[1:0]);
            mis = (nb == 0) ? 1'b1 : ((off % nb) != 0);
            for (int k = 0; k < 4; k++)
                if (k >= off && k < off + nb) lanes[3-k] = 1'b1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (i_req && d_req) e_i = last_was_d;
            else                e_i = i_req;
`else
            if (i_req && d_req) e_i = (denied >= LIM);
            else                e_i = i_req;
`endif
            e_d     = d_req && !e_i;
            e_en    = e_i || (e_d && !mis);
            e_we    = e_d && !mis && d_we;
            e_be    = !e_en ? 4'h0 : (e_i ? 4'hF : lanes);
            e_addr  = !e_en ? 32'h0 : ((e_i ? i_addr : d_addr) & 32'hFFFF_FFFC);
            e_wd    = e_we ? d_wdata : 32'h0;
            e_stall = (i_req && !e_i) || (d_req && !e_d);
        end

        check_output("i_gnt", 64'(i_gnt), 64'(e_i));
        check_output("d_gnt", 64'(d_gnt), 64'(e_d));
        check_output("mem_en", 64'(mem_en), 64'(e_en));
        check_output("mem_we", 64'(mem_we), 64'(e_we));
        check_output("mem_be", 64'(mem_be), 64'(e_be));
        check_output("mem_addr", 64'(mem_addr), 64'(e_addr));
        check_output("cpu_stall", 64'(cpu_stall), 64'(e_stall));
        check_output("i_rvalid", 64'(i_rvalid), 64'(e_irv));
        check_output("d_rvalid", 64'(d_rvalid), 64'(e_drv));
        check_output("d_err", 64'(d_err), 64'(e_err));
        if (e_we || reset) check_output("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        if (e_irv || reset) check_output("i_rdata", 64'(i_rdata), 64'(e_ird));
        if (e_drv || reset) check_output("d_rdata", 64'(d_rdata), 64'(e_drd));

        if (reset) begin
            denied = 0;
            last_was_d = 1'b0;
            pend = 0;
            for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
        end else begin
            pend = e_i ? 1 : (e_d && mis) ? 3 : (e_d && !d_we) ? 2 : 0;
            pend_data = ref_mem[e_i ? i_addr[5:2] : d_addr[5:2]];
            if (e_we)
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) ref_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            denied = (i_req && !e_i) ? ((denied + 1 > LIM) ? LIM : denied + 1) : 0;
            if (e_i)      last_was_d = 1'b0;
            else if (e_d) last_was_d = 1'b1;
        end
        m_i_gnt = e_i;
        m_d_gnt = e_d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic req, input logic we, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        d_req = req; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    endtask

    initial begin
        denied = 0; last_was_d = 0; pend = 0; pend_data = 0;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);

        // Reset held with both sides requesting
        i_req = 1; i_addr = 32'h40;
        apply_stimulus(1, 0, 2'b10, 32'h0, 32'h0);
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        reset = 0;
        run_cycle();
        d_req = 0;
        run_cycle();
        i_req = 0;
        run_cycle();

        // Long write then a lone fetch of the same word from an unaligned address
        apply_stimulus(1, 1, 2'b10, 32'h100, 32'hA5A5_1234);
        run_cycle();
        d_req = 0;
        run_cycle();
        i_req = 1; i_addr = 32'h102;
        run_cycle();
        i_req = 0;
        check_output("fetch_word", 64'(i_rdata), 64'(32'hA5A5_1234));
        run_cycle();

        // Byte write to the last lane
        apply_stimulus(1, 1, 2'b00, 32'h203, 32'h0000_00EE);
        run_cycle();
        d_req = 0;
        run_cycle();

        // Both sides requesting continuously
        i_req = 1; i_addr = 32'h20;
        apply_stimulus(1, 0, 2'b10, 32'h10, 32'h0);
        repeat (10) run_cycle();
        i_req = 0; d_req = 0;
        run_cycle();

        // Misaligned long read
        apply_stimulus(1, 0, 2'b10, 32'h306, 32'h0);
        run_cycle();
        d_req = 0;
        run_cycle();

        // Reset lands while a data read response is outstanding
        apply_stimulus(1, 0, 2'b10, 32'h8, 32'h0);
        run_cycle();
        d_req = 0;
        reset = 1;
        run_cycle();
        reset = 0;
        run_cycle();

        // Random traffic honouring the hold-until-grant rules
        repeat (300) begin
            if (!i_req || m_i_gnt) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 63));
            end
            if (!d_req || m_d_gnt)
                apply_stimulus(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                               2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom);
            run_cycle();
        end
        i_req = 0; d_req = 0;
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
